// File: rtl/random_delay_timer.sv
// Random-delay generator: a free-running Galois LFSR sets the delay length and a
// prescaled down-counter flags expiry. Supports abort and one-shot or auto-rearm modes.
module random_delay_timer #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  TAPS      = 8'hB8,
  parameter int unsigned       SEED      = 1,
  parameter int unsigned       PRESCALE  = 1,
  parameter int unsigned       MIN_DELAY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             auto_rearm,
  output logic [WIDTH-1:0] rnd,
  output logic [WIDTH:0]   count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(MIN_DELAY);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   count_q, count_d;
  logic [PS_W-1:0]  pre_q, pre_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   load_val;
  logic             tick;

  // One bit wider than the LFSR so the offset can never wrap the load value.
  assign load_val = {1'b0, lfsr_q} + MIN_W;
  assign tick     = (state_q == S_COUNT) && (pre_q == PS_LAST);

  always_comb begin
    if (lfsr_q == '0) begin
      lfsr_d = SEED_EFF;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end else begin
      lfsr_d = lfsr_q >> 1;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_EXPIRED: begin
          if (start) begin
            state_d = S_COUNT;
            count_d = load_val;
            pre_d   = '0;
          end
        end
        S_COUNT: begin
          if (!tick) begin
            pre_d = pre_q + PS_W'(1);
          end else begin
            pre_d = '0;
            if (count_q != '0) begin
              count_d = count_q - (WIDTH+1)'(1);
            end else begin
              done_d = 1'b1;
              if (auto_rearm) begin
                count_d = load_val;
              end else begin
                state_d = S_EXPIRED;
                count_d = '0;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q  <= SEED_EFF;
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign rnd     = lfsr_q;
  assign count   = count_q;
  assign busy    = (state_q == S_COUNT);
  assign expired = (state_q == S_EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer: three 4-bit instances (PRESCALE 1 and 4,
// SEED 1 and 0) sharing clock and reset, checked against hand-computed values.
module tb_random_delay_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, abort_a, auto_a;
  logic start_b, abort_b, auto_b;
  logic start_c, abort_c, auto_c;

  logic [3:0] rnd_a, rnd_b, rnd_c;
  logic [4:0] count_a, count_b, count_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       exp_a, exp_b, exp_c;

  random_delay_timer #(.WIDTH(4), .TAPS(4'hC), .SEED(1), .PRESCALE(1), .MIN_DELAY(2)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .auto_rearm(auto_a),
    .rnd(rnd_a), .count(count_a), .busy(busy_a), .done(done_a), .expired(exp_a));

  random_delay_timer #(.WIDTH(4), .TAPS(4'hC), .SEED(1), .PRESCALE(4), .MIN_DELAY(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .auto_rearm(auto_b),
    .rnd(rnd_b), .count(count_b), .busy(busy_b), .done(done_b), .expired(exp_b));

  random_delay_timer #(.WIDTH(4), .TAPS(4'hC), .SEED(0), .PRESCALE(1), .MIN_DELAY(2)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .auto_rearm(auto_c),
    .rnd(rnd_c), .count(count_c), .busy(busy_c), .done(done_c), .expired(exp_c));

  // Hand-derived LFSR sequence for TAPS=4'hC from state 1.
  logic [3:0] seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                           4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  int idx = 0;
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) idx = (idx + 1) % 15;
    else   idx = 0;
  endtask

  task automatic wait_rnd(input int target);
    int guard;
    guard = 0;
    while (idx != target && guard < 40) begin
      step();
      guard++;
    end
    check("wait_rnd", {28'd0, rnd_a}, {28'd0, seq[target]});
  endtask

  initial begin
    int n;
    int prev;

    reset = 1'b0;
    {start_a, abort_a, auto_a} = 3'b000;
    {start_b, abort_b, auto_b} = 3'b000;
    {start_c, abort_c, auto_c} = 3'b000;

    // Reset held for two edges
    step();
    step();
    check("rst_rnd_a",   rnd_a,   1);
    check("rst_count_a", count_a, 0);
    check("rst_busy_a",  busy_a,  0);
    check("rst_done_a",  done_a,  0);
    check("rst_exp_a",   exp_a,   0);
    check("rst_rnd_c_seed0", rnd_c, 1);

    // LFSR sequence and period
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("lfsr_seq", rnd_a, seq[k % 15]);
      check("lfsr_nonzero", (rnd_a != 4'h0), 1);
    end
    check("lfsr_period", rnd_a, 1);
    check("lfsr_seed0_seq", rnd_c, rnd_a == 4'h1 ? 4'h1 : 4'hx);

    // One-shot, PRESCALE=1, start with rnd=3 -> N=5
    wait_rnd(3);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("os_load_count", count_a, 5);
    check("os_load_busy",  busy_a,  1);
    for (int t = 1; t <= 5; t++) begin
      step();
      check("os_count", count_a, 5 - t);
      check("os_no_done", done_a, 0);
    end
    step();
    check("os_done",     done_a,  1);
    check("os_expired",  exp_a,   1);
    check("os_busy_low", busy_a,  0);
    check("os_count0",   count_a, 0);
    step();
    check("os_done_pulse", done_a, 0);
    check("os_exp_hold",   exp_a,  1);

    // Restart from EXPIRED, then abort mid-count
    n = seq[idx] + 2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("rs_exp_drop", exp_a,   0);
    check("rs_busy",     busy_a,  1);
    check("rs_count",    count_a, n);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("ab_mid_busy",  busy_a,  0);
    check("ab_mid_count", count_a, 0);
    check("ab_mid_exp",   exp_a,   0);
    check("ab_mid_done",  done_a,  0);

    // start together with abort stays IDLE
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    check("ab_start_busy",  busy_a,  0);
    check("ab_start_count", count_a, 0);

    // Abort on the expiry tick suppresses done
    n = seq[idx] + 2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("abx_load", count_a, n);
    for (int t = 1; t <= n; t++) step();
    check("abx_count0", count_a, 0);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("abx_no_done", done_a,  0);
    check("abx_busy",    busy_a,  0);
    check("abx_exp",     exp_a,   0);
    check("abx_count",   count_a, 0);
    step();
    check("abx_no_done_late", done_a, 0);

    // Prescaled one-shot, PRESCALE=4, N=5 -> done 24 cycles after start
    wait_rnd(3);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("ps_load", count_b, 5);
    for (int t = 1; t <= 24; t++) begin
      step();
      if (t == 3)                 check("ps_hold_pre_tick", count_b, 5);
      if (t % 4 == 0 && t <= 20)  check("ps_count", count_b, 5 - t / 4);
      if (t == 23)                check("ps_no_done_early", done_b, 0);
    end
    check("ps_done",    done_b, 1);
    check("ps_expired", exp_b,  1);
    check("ps_busy",    busy_b, 0);

    // Auto-rearm, PRESCALE=1: back-to-back periods of N+1, start ignored
    auto_a = 1'b1;
    n = seq[idx] + 2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("ar_load", count_a, n);
    for (int p = 0; p < 2; p++) begin
      for (int t = 1; t <= n; t++) begin
        if (t == 1) start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("ar_count", count_a, n - t);
        check("ar_busy",  busy_a,  1);
        check("ar_no_done", done_a, 0);
      end
      prev = seq[idx];
      step();
      check("ar_done",   done_a,  1);
      check("ar_busy_done", busy_a, 1);
      check("ar_reload", count_a, prev + 2);
      n = prev + 2;
    end
    abort_a = 1'b1;
    auto_a  = 1'b0;
    step();
    abort_a = 1'b0;
    check("ar_abort_busy", busy_a, 0);

    // SEED=0 instance: mid-count reset restores reset values
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step();
    check("s0_busy", busy_c, 1);
    reset = 1'b0;
    step();
    check("s0_rst_rnd",   rnd_c,   1);
    check("s0_rst_count", count_c, 0);
    check("s0_rst_busy",  busy_c,  0);
    check("s0_rst_done",  done_c,  0);
    check("s0_rst_exp",   exp_c,   0);
    reset = 1'b1;
    step();
    check("s0_after_rst", rnd_c, 4'hC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
